// File: rtl/proc_dmem_arb.sv
// Data-memory port arbiter: processor M-stage vs. buffered external requests, with bounded wait.
// Optional stall/conflict counters are built when PROC_DMEM_ARB_STATS_EN is defined.
module proc_dmem_arb #(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        proc_req_val,
    input  logic        proc_req_type,
    input  logic [31:0] proc_req_addr,
    input  logic [31:0] proc_req_wdata,
    output logic [31:0] proc_resp_rdata,
    output logic        proc_stall,
    input  logic        ext_req_val,
    output logic        ext_req_rdy,
    input  logic        ext_req_type,
    input  logic [31:0] ext_req_addr,
    input  logic [31:0] ext_req_wdata,
    output logic        ext_resp_val,
    output logic [31:0] ext_resp_rdata,
    output logic        mem_req_val,
    output logic        mem_req_type,
    output logic [31:0] mem_req_addr,
    output logic [31:0] mem_req_wdata,
    input  logic [31:0] mem_resp_rdata
`ifdef PROC_DMEM_ARB_STATS_EN
    ,
    output logic [31:0] stat_conflicts,
    output logic [31:0] stat_stalls
`endif
);

    // state  | meaning
    // IDLE   | no external request held; ready to accept one
    // WAIT   | external request held, waiting for the memory port
    // RESP   | external response presented for one cycle
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam int WCW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(MAX_WAIT);

    logic [1:0]     state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           hold_type_q, hold_type_d;
    logic [31:0]    hold_addr_q, hold_addr_d;
    logic [31:0]    hold_wdata_q, hold_wdata_d;
    logic [31:0]    ext_rdata_q, ext_rdata_d;

    logic in_wait, at_limit, ext_grant, ext_accept;

    assign in_wait    = (state_q == S_WAIT);
    assign at_limit   = (wait_cnt_q == WAIT_MAX);
    assign ext_grant  = in_wait & (!proc_req_val | at_limit);
    assign proc_stall = in_wait & at_limit & proc_req_val;

    // Ready is held low while reset is asserted, not just after the state resets.
    assign ext_req_rdy     = rst & (state_q == S_IDLE);
    assign ext_accept      = ext_req_val & ext_req_rdy;
    assign ext_resp_val    = (state_q == S_RESP);
    assign ext_resp_rdata  = ext_rdata_q;
    assign proc_resp_rdata = mem_resp_rdata;

    always_comb begin
        mem_req_val   = 1'b0;
        mem_req_type  = 1'b0;
        mem_req_addr  = 32'h0;
        mem_req_wdata = 32'h0;
        if (ext_grant) begin
            mem_req_val   = 1'b1;
            mem_req_type  = hold_type_q;
            mem_req_addr  = hold_addr_q;
            mem_req_wdata = hold_wdata_q;
        end else if (proc_req_val && !proc_stall && rst) begin
            mem_req_val   = 1'b1;
            mem_req_type  = proc_req_type;
            mem_req_addr  = proc_req_addr;
            mem_req_wdata = proc_req_wdata;
        end
    end

    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        hold_type_d  = hold_type_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        ext_rdata_d  = ext_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (ext_accept) begin
                    hold_type_d  = ext_req_type;
                    hold_addr_d  = ext_req_addr;
                    hold_wdata_d = ext_req_wdata;
                    wait_cnt_d   = '0;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ext_grant) begin
                    ext_rdata_d = hold_type_q ? 32'h0 : mem_resp_rdata;
                    state_d     = S_RESP;
                end else if (!at_limit) begin
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            wait_cnt_q   <= '0;
            hold_type_q  <= 1'b0;
            hold_addr_q  <= 32'h0;
            hold_wdata_q <= 32'h0;
            ext_rdata_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            hold_type_q  <= hold_type_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
            ext_rdata_q  <= ext_rdata_d;
        end
    end

`ifdef PROC_DMEM_ARB_STATS_EN
    logic [31:0] conflicts_q, stalls_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            conflicts_q <= 32'h0;
            stalls_q    <= 32'h0;
        end else begin
            if (in_wait && proc_req_val) conflicts_q <= conflicts_q + 32'd1;
            if (proc_stall)              stalls_q    <= stalls_q + 32'd1;
        end
    end

    assign stat_conflicts = conflicts_q;
    assign stat_stalls    = stalls_q;
`endif

endmodule
